// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    SA_IDLE  = 2'd0,
    SA_SHIFT = 2'd1,
    SA_DONE  = 2'd2
  } sa_state_t;

  localparam int unsigned SA_MAX_WIDTH = 64;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, shared across all bit positions by the serial controller.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell, one sum bit per SHIFT cycle, valid/ready on both sides.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned    CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  sa_state_t        state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_co;
  logic             accept, last_bit;

  assign accept   = in_valid & in_ready;
  assign last_bit = (state == SA_SHIFT) && (cnt == LAST);

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_s),
    .cout (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SA_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      SA_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SA_SHIFT;
      end
      SA_SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = SA_DONE;
      end
      SA_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = SA_IDLE;
      end
      default: state_nxt = SA_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      sum_sr <= '0;
      carry  <= cin;
      cnt    <= '0;
    end else if (state == SA_SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
      carry  <= fa_co;
      // Counter holds at the last position so it never wraps for power-of-two widths.
      if (!last_bit) cnt <= cnt + 1'b1;
    end
  end

  assign sum  = sum_sr;
  assign cout = carry;

`ifdef SERIAL_ADD_OVF_EN
  logic carry_msb;

  // Carry into the MSB is the carry flop just before the final bit is processed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        carry_msb <= 1'b0;
    else if (last_bit) carry_msb <= carry;
  end

  assign ovf = carry_msb ^ carry;
`endif

endmodule
